// File: rtl/sel_arbiter_pkg.sv
// Shared types and constants for the sel_arbiter block.
// State encoding, mux select values and the default hold bound.
// Build option SEL_ARBITER_FAIR_EN is consumed by sel_arbiter.sv.
package sel_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int HOLD_MAX_DEF = 8;

endpackage

// File: rtl/sel_arbiter_hold_timer.sv
// hold_timer: saturating up-counter with synchronous clear.
// Latency: count/at_max are registered; clr wins over en.
// No backpressure: the counter simply stops at HOLD_MAX-1.
module hold_timer #(
  parameter int HOLD_MAX = 8,
  localparam int CW      = $clog2(HOLD_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on grant entry/idle, otherwise count up and stick at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sel_arbiter.sv
// sel_arbiter: two-requester grant FSM driving a 2:1 mux select, bounded hold time.
// Latency: 1 cycle request-to-grant; every output is registered.
// Holder keeps the grant until done/req drop, or is pre-empted after HOLD_MAX cycles
// while the other side waits. Macro SEL_ARBITER_FAIR_EN selects round-robin ties.
module sel_arbiter
  import sel_arbiter_pkg::*;
#(
  parameter int  HOLD_MAX = HOLD_MAX_DEF,
  localparam int CW       = $clog2(HOLD_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          done,
  output logic          grant_a,
  output logic          grant_b,
  output logic          sel,
  output logic          preempt,
  output logic [CW-1:0] hold_cnt
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   preempt_q, preempt_d;
  logic   tmr_clr;
  logic   tmr_en;
  logic   at_max;
  state_e tie_state;

`ifdef SEL_ARBITER_FAIR_EN
  // Most recently granted side; resets to B so A wins the first tie.
  // Only the round-robin tie-break reads it, so only that build keeps it.
  logic last_q, last_d;

  // Round-robin: a tie from IDLE goes to the side that was not granted last.
  always_comb begin
    tie_state = (last_q == SEL_B) ? GNT_A : GNT_B;
  end

  // Record the side of every new grant.
  always_comb begin
    last_d = last_q;
    if (state_d == GNT_A) begin
      last_d = SEL_A;
    end else if (state_d == GNT_B) begin
      last_d = SEL_B;
    end
  end

  // Last-granted register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SEL_B;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: A always wins a tie from IDLE.
  always_comb begin
    tie_state = GNT_A;
  end
`endif

  // Next-state and pre-emption decision. A release always hands straight to a
  // waiting other side, which is also the round-robin "yield" on release.
  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = tie_state;
        end else if (req_a) begin
          state_d = GNT_A;
        end else if (req_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (done || !req_a) begin
          state_d = req_b ? GNT_B : IDLE;
        end else if (at_max && req_b) begin
          state_d   = GNT_B;
          preempt_d = 1'b1;
        end
      end
      GNT_B: begin
        if (done || !req_b) begin
          state_d = req_a ? GNT_A : IDLE;
        end else if (at_max && req_a) begin
          state_d   = GNT_A;
          preempt_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select follows the grant being entered and holds through IDLE.
  always_comb begin
    sel_d = sel_q;
    if (state_d == GNT_A) begin
      sel_d = SEL_A;
    end else if (state_d == GNT_B) begin
      sel_d = SEL_B;
    end
  end

  // Timer restarts on every grant entry (including hand-overs) and sits at 0 in IDLE.
  always_comb begin
    tmr_clr = (state_d == IDLE) || (state_d != state_q);
    tmr_en  = (state_q != IDLE);
  end

  // State, select and pre-emption pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= SEL_A;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      preempt_q <= preempt_d;
    end
  end

  hold_timer #(
    .HOLD_MAX (HOLD_MAX)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .cnt    (hold_cnt),
    .at_max (at_max)
  );

  assign grant_a = (state_q == GNT_A);
  assign grant_b = (state_q == GNT_B);
  assign sel     = sel_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// Directed bench for sel_arbiter with HOLD_MAX = 8.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_sel_arbiter;

  localparam int HM = 8;
  localparam int CW = $clog2(HM);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a;
  logic          req_b;
  logic          done;
  logic          grant_a;
  logic          grant_b;
  logic          sel;
  logic          preempt;
  logic [CW-1:0] hold_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  sel_arbiter #(
    .HOLD_MAX (HM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .done     (done),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .sel      (sel),
    .preempt  (preempt),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // grant_a, grant_b, sel, preempt, hold_cnt in one call
  task automatic check_all(input string tag, input int ga, input int gb,
                           input int s, input int p, input int h);
    check({tag, ".grant_a"}, int'(grant_a), ga);
    check({tag, ".grant_b"}, int'(grant_b), gb);
    check({tag, ".sel"},     int'(sel),     s);
    check({tag, ".preempt"}, int'(preempt), p);
    check({tag, ".hold_cnt"}, int'(hold_cnt), h);
  endtask

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    done  = 1'b0;
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check_all("idle_after_reset", 0, 0, 0, 0, 0);

    // Single requester: count 0..7 then saturate, never pre-empted.
    req_a = 1'b1;
    tick();
    check_all("single_grant", 1, 0, 0, 0, 0);
    for (int k = 1; k < 20; k++) begin
      tick();
      check("single_cnt", int'(hold_cnt), (k < HM - 1) ? k : HM - 1);
      check("single_preempt", int'(preempt), 0);
      check("single_hold", int'(grant_a), 1);
    end
    req_a = 1'b0;
    tick();
    check_all("single_release", 0, 0, 0, 0, 0);

    // Pre-emption: B arrives 2 cycles after A's grant; switch 8 cycles after grant edge.
    req_a = 1'b1;
    tick();
    check_all("pre_grant_a", 1, 0, 0, 0, 0);
    tick();
    tick();
    req_b = 1'b1;
    for (int k = 3; k < HM; k++) begin
      tick();
      check_all("pre_wait", 1, 0, 0, 0, k);
    end
    tick();
    check_all("pre_switch", 0, 1, 1, 1, 0);
    tick();
    check_all("pre_after", 0, 1, 1, 0, 1);

    // B drops request while A waits: direct hand-over back to A.
    req_b = 1'b0;
    tick();
    check_all("release_to_a", 1, 0, 0, 0, 0);

    // done while B waits: hand-over with no IDLE bubble.
    req_b = 1'b1;
    done  = 1'b1;
    tick();
    check_all("done_handover", 0, 1, 1, 0, 0);
    done = 1'b0;

    // done exactly at the pre-emption point counts as a release.
    repeat (HM - 1) tick();
    check_all("at_max_b", 0, 1, 1, 0, HM - 1);
    done = 1'b1;
    tick();
    check_all("done_at_max", 1, 0, 0, 0, 0);
    done = 1'b0;

    // sel keeps its last value through IDLE.
    req_a = 1'b0;
    tick();
    check_all("to_b", 0, 1, 1, 0, 0);
    req_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("idle_sel_hold", 0, 0, 1, 0, 0);
    end

    // Reset in the middle of a B grant with hold_cnt = 3.
    req_b = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_all("pre_reset", 0, 1, 1, 0, 3);
    rst = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    req_b = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_all("post_reset_idle", 0, 0, 0, 0, 0);

    // Ties from IDLE, twice with a release to IDLE between them.
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
    check_all("tie1", 1, 0, 0, 0, 0);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    check_all("tie_idle", 0, 0, 0, 0, 0);
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
`ifdef SEL_ARBITER_FAIR_EN
    check_all("tie2", 0, 1, 1, 0, 0);
`else
    check_all("tie2", 1, 0, 0, 0, 0);
`endif
    req_a = 1'b0;
    req_b = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
